shift_frame_deser: RTL and testbench

//   Parametrised multi-lane shift register with selectable direction, parallel load, serial shift-out
//   and frame-completion handshake. Accumulates DATA_WIDTH/LANES shifts into a frame and presents a

---
 rtl/shift_frame_deser_if.sv | 45 ++++
 rtl/shift_frame_deser.sv | 178 +++++++++++++++++
 tb/tb_shift_frame_deser.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_frame_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_frame_deser_if
// Description : Control/data/frame bundle between a serial front-end driver
//               and shift_frame_deser.
//   clr          master->slave  synchronous clear
//   en           master->slave  operation enable (0 = hold)
//   mode   [1:0] master->slave  00 hold, 01 left, 10 right, 11 load
//   din          master->slave  serial input bits (LANES wide)
//   load_data    master->slave  parallel load value
//   frame_ready  master->slave  consumer accepts the frame snapshot
//   dout         slave->master  live shift register contents
//   sout         slave->master  bits shifted out by the latest shift
//   frame_valid  slave->master  frame snapshot available
//   frame_data   slave->master  frame snapshot
//   overflow     slave->master  sticky: frame dropped while one was pending
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_frame_deser_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 1
);
  logic                  clr;
  logic                  en;
  logic [1:0]            mode;
  logic [LANES-1:0]      din;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  frame_ready;
  logic [DATA_WIDTH-1:0] dout;
  logic [LANES-1:0]      sout;
  logic                  frame_valid;
  logic [DATA_WIDTH-1:0] frame_data;
  logic                  overflow;

  modport master (
    output clr, en, mode, din, load_data, frame_ready,
    input  dout, sout, frame_valid, frame_data, overflow
  );

  modport slave (
    input  clr, en, mode, din, load_data, frame_ready,
    output dout, sout, frame_valid, frame_data, overflow
  );
endinterface
`default_nettype wire

// File: rtl/shift_frame_deser.sv
`default_nettype none
// ============================================================================
// Module      : shift_frame_deser
// Description : Multi-lane shift register with left/right shift, parallel
//               load and serial shift-out. Every DATA_WIDTH/LANES shifts form
//               a frame whose post-shift value is offered on a valid/ready
//               handshake; a frame completing while the previous one is
//               still pending is dropped and flagged in a sticky overflow.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - shift_frame_deser_if.slave (controls, data, frame)
// Parameters  : DATA_WIDTH - register/frame width
//               LANES      - bits per shift; must divide DATA_WIDTH and
//                            DATA_WIDTH/LANES must be at least 2
//               SYNC_IN    - 1: en/mode/din/load_data registered once first
// Revision    : 1.0 - initial release
// ============================================================================
module shift_frame_deser #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 1,
  parameter int SYNC_IN    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_frame_deser_if.slave bus
);

  localparam int c_frame = DATA_WIDTH / LANES;
  localparam int c_cnt_w = $clog2(c_frame);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_frame - 1);

  localparam logic [1:0] c_mode_hold  = 2'b00;
  localparam logic [1:0] c_mode_left  = 2'b01;
  localparam logic [1:0] c_mode_right = 2'b10;
  localparam logic [1:0] c_mode_load  = 2'b11;

  // Effective (possibly staged) operation inputs
  logic                  w_en;
  logic [1:0]            w_mode;
  logic [LANES-1:0]      w_din;
  logic [DATA_WIDTH-1:0] w_load;

  generate
    if (SYNC_IN != 0) begin : g_sync
      logic                  en_q;
      logic [1:0]            mode_q;
      logic [LANES-1:0]      din_q;
      logic [DATA_WIDTH-1:0] load_q;

      // clr flushes the stage so an operation captured just before the
      // clear cannot leak into the freshly cleared register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          en_q   <= 1'b0;
          mode_q <= 2'b00;
          din_q  <= '0;
          load_q <= '0;
        end else if (bus.clr) begin
          en_q   <= 1'b0;
          mode_q <= 2'b00;
          din_q  <= '0;
          load_q <= '0;
        end else begin
          en_q   <= bus.en;
          mode_q <= bus.mode;
          din_q  <= bus.din;
          load_q <= bus.load_data;
        end
      end

      assign w_en   = en_q;
      assign w_mode = mode_q;
      assign w_din  = din_q;
      assign w_load = load_q;
    end else begin : g_direct
      assign w_en   = bus.en;
      assign w_mode = bus.mode;
      assign w_din  = bus.din;
      assign w_load = bus.load_data;
    end
  endgenerate

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [LANES-1:0]      sout_q, sout_d;
  logic [c_cnt_w-1:0]    cnt_q, cnt_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [DATA_WIDTH-1:0] frame_data_q, frame_data_d;
  logic                  overflow_q, overflow_d;
  logic                  w_shift;
  logic                  w_frame_done;
  logic                  w_accept;

  // Shift datapath and shift counter
  always_comb begin
    dout_d  = dout_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    w_shift = 1'b0;
    if (w_en) begin
      case (w_mode)
        c_mode_hold: ;
        c_mode_left: begin
          dout_d  = {dout_q[DATA_WIDTH-LANES-1:0], w_din};
          sout_d  = dout_q[DATA_WIDTH-1 -: LANES];
          w_shift = 1'b1;
        end
        c_mode_right: begin
          dout_d  = {w_din, dout_q[DATA_WIDTH-1:LANES]};
          sout_d  = dout_q[LANES-1:0];
          w_shift = 1'b1;
        end
        c_mode_load: begin
          // A load restarts frame alignment but never produces a frame
          dout_d = w_load;
          cnt_d  = '0;
        end
      endcase
    end
    // Direction changes do not disturb the count; only shifts advance it
    if (w_shift) begin
      cnt_d = (cnt_q == c_cnt_last) ? '0 : cnt_q + 1'b1;
    end
    w_frame_done = w_shift && (cnt_q == c_cnt_last);
  end

  // Frame handshake
  always_comb begin
    w_accept      = frame_valid_q & bus.frame_ready;
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    overflow_d    = overflow_q;
    if (w_frame_done) begin
      // A slot frees up either because nothing is pending or because the
      // pending frame is taken on this very edge.
      if (!frame_valid_q || w_accept) begin
        frame_valid_d = 1'b1;
        frame_data_d  = dout_d;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (w_accept) begin
      frame_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q        <= '0;
      sout_q        <= '0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      overflow_q    <= 1'b0;
    end else if (bus.clr) begin
      dout_q        <= '0;
      sout_q        <= '0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      dout_q        <= dout_d;
      sout_q        <= sout_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.sout        = sout_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_data  = frame_data_q;
  assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_frame_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_frame_deser
// Description : Self-checking bench for shift_frame_deser. Three instances
//               (8b/1 lane staged, 16b/4 lanes staged, 8b/2 lanes direct)
//               share one stimulus stream and are compared every cycle with
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_shift_frame_deser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic        clr_r = 1'b0;
  logic        en_r = 1'b0;
  logic [1:0]  md_r = 2'b00;
  logic [3:0]  din_r = 4'h0;
  logic [15:0] ld_r = 16'h0;
  logic        rdy_r = 1'b0;

  shift_frame_deser_if #(.DATA_WIDTH(8),  .LANES(1)) if0();
  shift_frame_deser_if #(.DATA_WIDTH(16), .LANES(4)) if1();
  shift_frame_deser_if #(.DATA_WIDTH(8),  .LANES(2)) if2();

  assign if0.clr = clr_r;  assign if1.clr = clr_r;  assign if2.clr = clr_r;
  assign if0.en  = en_r;   assign if1.en  = en_r;   assign if2.en  = en_r;
  assign if0.mode = md_r;  assign if1.mode = md_r;  assign if2.mode = md_r;
  assign if0.frame_ready = rdy_r;
  assign if1.frame_ready = rdy_r;
  assign if2.frame_ready = rdy_r;
  assign if0.din = din_r[0:0];
  assign if1.din = din_r;
  assign if2.din = din_r[1:0];
  assign if0.load_data = ld_r[7:0];
  assign if1.load_data = ld_r;
  assign if2.load_data = ld_r[7:0];

  shift_frame_deser #(.DATA_WIDTH(8),  .LANES(1), .SYNC_IN(1)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  shift_frame_deser #(.DATA_WIDTH(16), .LANES(4), .SYNC_IN(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  shift_frame_deser #(.DATA_WIDTH(8),  .LANES(2), .SYNC_IN(0)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one slot per instance
  int     mw[3];
  int     ml[3];
  int     ms[3];
  longint m_dout[3], m_sout[3], m_fv[3], m_fd[3], m_ov[3];
  int     m_cnt[3];
  bit     st_en[3];
  int     st_md[3];
  longint st_din[3], st_ld[3];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_dout[k] = 0; m_sout[k] = 0; m_fv[k] = 0; m_fd[k] = 0; m_ov[k] = 0;
      m_cnt[k] = 0;
      st_en[k] = 0; st_md[k] = 0; st_din[k] = 0; st_ld[k] = 0;
    end
  endtask

  task automatic model_apply(input int k, input bit e, input int md,
                             input longint di, input longint l);
    longint mask, lm;
    int     w, lw;
    bit     shifted, done, acc;
    w  = mw[k];
    lw = ml[k];
    mask = (longint'(1) << w) - 1;
    lm   = (longint'(1) << lw) - 1;
    shifted = 0;
    if (e) begin
      if (md == 1) begin
        m_sout[k] = (m_dout[k] >> (w - lw)) & lm;
        m_dout[k] = ((m_dout[k] << lw) | di) & mask;
        shifted = 1;
      end else if (md == 2) begin
        m_sout[k] = m_dout[k] & lm;
        m_dout[k] = (m_dout[k] >> lw) | (di << (w - lw));
        shifted = 1;
      end else if (md == 3) begin
        m_dout[k] = l;
        m_cnt[k]  = 0;
      end
    end
    done = 0;
    if (shifted) begin
      m_cnt[k] = (m_cnt[k] + 1) % (w / lw);
      done = (m_cnt[k] == 0);
    end
    acc = (m_fv[k] != 0) && rdy_r;
    if (done) begin
      if (m_fv[k] == 0 || acc) begin
        m_fv[k] = 1;
        m_fd[k] = m_dout[k];
      end else begin
        m_ov[k] = 1;
      end
    end else if (acc) begin
      m_fv[k] = 0;
    end
  endtask

  // One rising edge as seen by the model
  task automatic model_edge();
    longint di, l;
    if (!rst_n) return;
    for (int k = 0; k < 3; k++) begin
      di = longint'(din_r) & ((longint'(1) << ml[k]) - 1);
      l  = longint'(ld_r) & ((longint'(1) << mw[k]) - 1);
      if (clr_r) begin
        m_dout[k] = 0; m_sout[k] = 0; m_fv[k] = 0; m_fd[k] = 0; m_ov[k] = 0;
        m_cnt[k] = 0;
        st_en[k] = 0; st_md[k] = 0; st_din[k] = 0; st_ld[k] = 0;
      end else if (ms[k] != 0) begin
        model_apply(k, st_en[k], st_md[k], st_din[k], st_ld[k]);
        st_en[k] = en_r; st_md[k] = int'(md_r); st_din[k] = di; st_ld[k] = l;
      end else begin
        model_apply(k, en_r, int'(md_r), di, l);
      end
    end
  endtask

  task automatic check_dut(input int k, input longint d, input longint s,
                           input longint fv, input longint fd, input longint ov);
    check_val($sformatf("d%0d.dout", k), d, m_dout[k]);
    check_val($sformatf("d%0d.sout", k), s, m_sout[k]);
    check_val($sformatf("d%0d.frame_valid", k), fv, m_fv[k]);
    check_val($sformatf("d%0d.frame_data", k), fd, m_fd[k]);
    check_val($sformatf("d%0d.overflow", k), ov, m_ov[k]);
  endtask

  task automatic check_all();
    check_dut(0, if0.dout, if0.sout, if0.frame_valid, if0.frame_data, if0.overflow);
    check_dut(1, if1.dout, if1.sout, if1.frame_valid, if1.frame_data, if1.overflow);
    check_dut(2, if2.dout, if2.sout, if2.frame_valid, if2.frame_data, if2.overflow);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit e, input logic [1:0] m, input logic [3:0] d);
    clr_r = 1'b0; en_r = e; md_r = m; din_r = d;
  endtask

  task automatic do_clear();
    drive(1'b0, 2'b00, 4'h0);
    clr_r = 1'b1;
    cycle();
    clr_r = 1'b0;
  endtask

  logic [7:0] bits;

  initial begin
    mw[0] = 8;  ml[0] = 1; ms[0] = 1;
    mw[1] = 16; ml[1] = 4; ms[1] = 1;
    mw[2] = 8;  ml[2] = 2; ms[2] = 0;
    model_reset();

    // Reset state
    #2 check_all();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Left-shift stream 1,0,1,1,0,0,1,0 -> 8'hB2
    do_clear();
    rdy_r = 1'b0;
    bits = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b01, {3'b000, bits[7-i]});
      cycle();
    end
    drive(1'b0, 2'b00, 4'h0);
    cycle();
    check_val("t1.frame_valid", if0.frame_valid, 1);
    check_val("t1.frame_data", if0.frame_data, 8'hB2);
    check_val("t1.dout", if0.dout, 8'hB2);

    // Same stream shifting right -> 8'h4D
    do_clear();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b10, {3'b000, bits[7-i]});
      cycle();
    end
    drive(1'b0, 2'b00, 4'h0);
    cycle();
    check_val("t2.frame_data", if0.frame_data, 8'h4D);

    // Load A5 then two left shifts of 0
    do_clear();
    ld_r = 16'h00A5;
    drive(1'b1, 2'b11, 4'h0);
    cycle();
    drive(1'b1, 2'b01, 4'h0);
    cycle();
    cycle();
    check_val("t3.sout1", if0.sout, 1);
    check_val("t3.dout1", if0.dout, 8'h4A);
    drive(1'b0, 2'b00, 4'h0);
    cycle();
    check_val("t3.sout2", if0.sout, 0);
    check_val("t3.dout2", if0.dout, 8'h94);
    // Six more shifts complete the frame started by the load
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'b01, 4'($urandom));
      cycle();
    end
    drive(1'b0, 2'b00, 4'h0);
    check_val("t3.no_early_frame", if0.frame_valid, 0);
    cycle();
    check_val("t3.frame_valid", if0.frame_valid, 1);

    // Overflow: two frames with no consumer
    do_clear();
    rdy_r = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b01, 4'($urandom));
      cycle();
    end
    drive(1'b0, 2'b00, 4'h0);
    cycle();
    check_val("t4.overflow", if0.overflow, 1);
    rdy_r = 1'b1;
    cycle();
    rdy_r = 1'b0;
    check_val("t4.accepted", if0.frame_valid, 0);
    check_val("t4.overflow_sticky", if0.overflow, 1);
    do_clear();
    check_val("t4.clr_overflow", if0.overflow, 0);

    // Completion coinciding with acceptance
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b01, 4'($urandom));
      cycle();
    end
    drive(1'b0, 2'b00, 4'h0);
    rdy_r = 1'b1;
    cycle();
    rdy_r = 1'b0;
    check_val("t5.frame_valid", if0.frame_valid, 1);
    check_val("t5.overflow", if0.overflow, 0);

    // 16-bit, 4 lanes: nibbles 1,2,3,4 -> 16'h1234
    do_clear();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'b01, 4'(i));
      cycle();
    end
    drive(1'b0, 2'b00, 4'h0);
    cycle();
    check_val("t6.frame_valid", if1.frame_valid, 1);
    check_val("t6.frame_data", if1.frame_data, 16'h1234);

    // Asynchronous reset with two shifts into a frame
    do_clear();
    drive(1'b1, 2'b01, 4'h5);
    cycle();
    cycle();
    drive(1'b0, 2'b00, 4'h0);
    cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("t6.rst_dout", if1.dout, 0);
    check_all();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b01, 4'($urandom));
      cycle();
    end

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      en_r  = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 9))
        0:          md_r = 2'b00;
        1:          md_r = 2'b11;
        2, 3, 4, 5: md_r = 2'b01;
        default:    md_r = 2'b10;
      endcase
      din_r = 4'($urandom);
      ld_r  = 16'($urandom);
      rdy_r = ($urandom_range(0, 2) == 0);
      clr_r = ($urandom_range(0, 99) == 0);
      cycle();
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1 check_all();
        #1 rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
